// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - PS/2 scan-code parser and turn queue for the snake game; optional SNAKE_ARROW_KEYS_EN
module snake_dir_ctrl #(
  parameter int         QDEPTH    = 2,
  parameter logic [1:0] RESET_DIR = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  input  logic       tick,
  input  logic       clear,
  output logic [1:0] dir,
  output logic       turn_taken,
  output logic [2:0] q_count,
  output logic       drop_pulse,
  output logic       esc_pulse,
  output logic       enter_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} pstate_e;

  localparam logic [1:0] LAST  = 2'(QDEPTH - 1);
  localparam logic [2:0] DEPTH = 3'(QDEPTH);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  pstate_e    state_q, state_d;
  // Storage is sized for the largest legal depth; pointers never reach unused slots.
  logic [1:0] mem_q [4];
  logic [1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] dir_q, dir_d;
  logic       tt_q, tt_d, drop_q, drop_d, esc_q, esc_d, enter_q, enter_d;

  logic       make_en, make_ext;
  logic       req_en, esc_hit, enter_hit;
  logic [1:0] req_dir, tail_ptr, ref_dir;
  logic       full, accept, pop, push_en;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Parser: track break/extended prefixes and flag when a make byte is present.
  always_comb begin
    state_d  = state_q;
    make_en  = 1'b0;
    make_ext = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code_byte == 8'hF0)      state_d = S_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else                         make_en = 1'b1;
        end
        S_EXT: begin
          if (code_byte == 8'hF0)      state_d = S_EXT_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else begin
            make_en  = 1'b1;
            make_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK:   state_d = (code_byte == 8'hF0) ? S_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decode make codes into a direction request or an Esc/Enter command.
  always_comb begin
    req_en    = 1'b0;
    req_dir   = DIR_RIGHT;
    esc_hit   = 1'b0;
    enter_hit = 1'b0;
    if (make_en && !make_ext) begin
      case (code_byte)
        8'h1D:   begin req_en = 1'b1; req_dir = DIR_UP;    end
        8'h1C:   begin req_en = 1'b1; req_dir = DIR_LEFT;  end
        8'h1B:   begin req_en = 1'b1; req_dir = DIR_DOWN;  end
        8'h23:   begin req_en = 1'b1; req_dir = DIR_RIGHT; end
        8'h76:   esc_hit   = 1'b1;
        8'h5A:   enter_hit = 1'b1;
        default: ;
      endcase
    end
`ifdef SNAKE_ARROW_KEYS_EN
    if (make_en && make_ext) begin
      case (code_byte)
        8'h75:   begin req_en = 1'b1; req_dir = DIR_UP;    end
        8'h6B:   begin req_en = 1'b1; req_dir = DIR_LEFT;  end
        8'h72:   begin req_en = 1'b1; req_dir = DIR_DOWN;  end
        8'h74:   begin req_en = 1'b1; req_dir = DIR_RIGHT; end
        default: ;
      endcase
    end
`endif
  end

  // Turn queue: filter requests against the newest pending heading, pop on tick.
  always_comb begin
    tail_ptr = (wr_ptr_q == 2'd0) ? LAST : wr_ptr_q - 2'd1;
    ref_dir  = (cnt_q != 3'd0) ? mem_q[tail_ptr] : dir_q;
    full     = (cnt_q == DEPTH);
    accept   = req_en && !full && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'd2));
    pop      = tick && (cnt_q != 3'd0);
    push_en  = accept && !clear;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    tt_d     = 1'b0;
    drop_d   = 1'b0;
    esc_d    = 1'b0;
    enter_d  = 1'b0;
    if (clear) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      cnt_d    = 3'd0;
      dir_d    = RESET_DIR;
    end else begin
      if (pop) begin
        dir_d    = mem_q[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
        tt_d     = 1'b1;
      end
      if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d   = cnt_q + {2'b00, accept} - {2'b00, pop};
      drop_d  = req_en && !accept;
      esc_d   = esc_hit;
      enter_d = enter_hit;
    end
  end

  // State registers and queue storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      dir_q    <= RESET_DIR;
      tt_q     <= 1'b0;
      drop_q   <= 1'b0;
      esc_q    <= 1'b0;
      enter_q  <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 2'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      tt_q     <= tt_d;
      drop_q   <= drop_d;
      esc_q    <= esc_d;
      enter_q  <= enter_d;
      if (push_en) mem_q[wr_ptr_q] <= req_dir;
    end
  end

  assign dir         = dir_q;
  assign turn_taken  = tt_q;
  assign q_count     = cnt_q;
  assign drop_pulse  = drop_q;
  assign esc_pulse   = esc_q;
  assign enter_pulse = enter_q;

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Scan-code consumer placed directly downstream of the PS/2 keyboard receiver. It parses the byte stream (make, break `F0` and extended `E0` prefixes) into direction, Esc and Enter commands. Direction requests go into a small turn queue, which rejects 180° reversals and duplicates. The game FSM pops one turn per movement tick.

## Interface
Parameters:
- `QDEPTH`, default 2: turn queue depth; legal values 1–4.
- `RESET_DIR`, default 2'd0: direction applied on reset and on `clear`.

Ports:
- `clk` in 1: system clock; every input is synchronous to it.
- `reset` in 1: asynchronous, active-high; clears all state.
- `code_valid` in 1: one-cycle strobe; a new scan byte is present on `code_byte`.
- `code_byte` in 8: PS/2 set-2 scan byte.
- `tick` in 1: one-cycle game step strobe; pops one queued turn.
- `clear` in 1: synchronous flush, used on game restart.
- `dir` out 2: current heading; 0 = right, 1 = up, 2 = left, 3 = down.
- `turn_taken` out 1: one-cycle pulse; `dir` changed on this tick.
- `q_count` out 3: number of queued turns.
- `drop_pulse` out 1: one-cycle pulse; a direction request was rejected.
- `esc_pulse` out 1: one-cycle pulse on an Esc make code.
- `enter_pulse` out 1: one-cycle pulse on an Enter make code.

## Operation
- Parser FSM. States are IDLE, BRK, EXT and EXT_BRK. It advances only on `code_valid`.
  - IDLE: `F0` → BRK; `E0` → EXT; any other byte is a make code and is decoded, staying in IDLE.
  - EXT: `F0` → EXT_BRK; any other byte is an extended make code and is decoded, → IDLE.
  - BRK and EXT_BRK: the next byte is discarded (key release), → IDLE.
  - `E0` received in EXT: stay in EXT. `F0` received in BRK: stay in BRK.
- Make decode:
  - `1D` (W) = up; `1C` (A) = left; `1B` (S) = down; `23` (D) = right.
  - `76` = Esc; `5A` = Enter.
  - Other bytes are ignored without pulses.
- Reference direction is the queue tail if the queue is non-empty, otherwise `dir`.
- A request is rejected and `drop_pulse` raised if any of these hold:
  - it equals the reference direction (this covers typematic repeats);
  - it equals reference ^ 2 (reversal);
  - the queue is full.
- Otherwise the request is pushed at the tail.
- On `tick`:
  - If the queue is non-empty, the head is popped into `dir` and `turn_taken` pulses.
  - If the queue is empty, nothing changes.
- `tick` and push in the same cycle:
  - The pop uses the pre-push head, and the reference check uses the pre-pop tail.
  - Full queue plus simultaneous tick: the push is still rejected (full is evaluated before the pop).
  - Empty queue: the pushed turn is not applied on that tick; it is applied on the next tick.
- `clear`:
  - empties the queue, sets `dir` = `RESET_DIR`, sets the parser to IDLE, and suppresses all pulses that cycle;
  - takes priority over `code_valid` and `tick`.
- Queue is a circular buffer. Read and write pointers wrap modulo `QDEPTH`. `q_count` is 0..`QDEPTH`.

## Timing
- Reset values:
  - `dir` = `RESET_DIR`; `q_count` = 0;
  - all pulses 0; parser IDLE; pointers 0.
- All outputs are registered.
- `code_valid` at edge N → `q_count`, `drop_pulse`, `esc_pulse` and `enter_pulse` valid after edge N (visible cycle N+1). Each pulse lasts exactly one cycle.
- `tick` at edge N → `dir` and `turn_taken` updated after edge N.
- Back-to-back `code_valid` on consecutive cycles is supported at full rate.
- `reset` mid-sequence (e.g. in BRK) aborts the sequence immediately. The next byte is parsed from IDLE.

## Configuration
- `SNAKE_ARROW_KEYS_EN` defined:
  - extended make codes decode as directions: `E0 75` = up, `E0 6B` = left, `E0 72` = down, `E0 74` = right;
  - other extended codes are ignored.
- Not defined:
  - the EXT and EXT_BRK states still exist and consume bytes;
  - all extended make codes are ignored, and no direction is produced from arrow keys.

## Test plan
- Reset, `dir` = right (0), byte `1D`, then `tick` → `q_count` 1 then 0; `dir` = 1; one `turn_taken` pulse.
- `dir` = right, bytes `1C` (left) then `1D 1D` → left is dropped; up is queued once; the second `1D` is dropped; `q_count` = 1; two `drop_pulse` pulses.
- Bytes `F0 1D` → no queue change, no pulses; parser back in IDLE (a following `1B` is queued as down).
- Bytes `1D`, `1C`, `1B` with no tick → the first two are queued and `1B` is dropped (queue full, `q_count` = 2). Ticks then pop up, then left.
- `code_valid` (`23`) and `tick` in the same cycle, queue holding up:
  - the tick pops up into `dir`;
  - right is checked against up, accepted, and leaves `q_count` = 1.
- Bytes `E0 74`, then `76` and `5A`:
  - with `SNAKE_ARROW_KEYS_EN`, right is queued (after first turning up);
  - without it, nothing is queued;
  - in both builds, `esc_pulse` and then `enter_pulse` each pulse once.
